// File: rtl/pokey_pkg.sv
// pokey_pkg: shared types and constants for the POKEY pot scan logic.
// Contents: the scan state enum, the count constants, and the register offsets that decode writes.
// No logic lives here.
package pokey_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    SCAN = 1'b1
  } scan_state_t;

  localparam int POT_MAX_COUNT     = 228;
  localparam int POKEY_LINE_CYCLES = 114;

  // Register offsets used by the POKEY decode. POTGO and SKCTL drive
  // potgo_strobe and fast_scan. POTn and ALLPOT read back from this block.
  localparam logic [3:0] POTGO  = 4'hB;
  localparam logic [3:0] SKCTL  = 4'hF;
  localparam logic [3:0] ALLPOT = 4'h8;

endpackage

// File: rtl/pot_scan_sequencer_if.sv
// pot_scan_sequencer_if: register-decode and pin side signals of the pot scan sequencer.
// master: drives potgo_strobe, fast_scan, pot_in and rd_sel. It receives rd_data, allpot, dump_en, pot_ctr and scan_busy.
// slave: the sequencer itself, which has the opposite directions. There is no handshake; every signal is level or single-pulse.
interface pot_scan_sequencer_if;
  logic       potgo_strobe;
  logic       fast_scan;
  logic [7:0] pot_in;
  logic [2:0] rd_sel;
  logic [7:0] rd_data;
  logic [7:0] allpot;
  logic [7:0] dump_en;
  logic [7:0] pot_ctr;
  logic       scan_busy;

  modport master (
    output potgo_strobe, fast_scan, pot_in, rd_sel,
    input  rd_data, allpot, dump_en, pot_ctr, scan_busy
  );

  modport slave (
    input  potgo_strobe, fast_scan, pot_in, rd_sel,
    output rd_data, allpot, dump_en, pot_ctr, scan_busy
  );
endinterface

// File: rtl/pot_line_timer.sv
// pot_line_timer: scanline divider. It produces one tick every LINE_CYCLES o2 cycles, or one tick every cycle when fast=1.
// Ports: o2 is the clock and rst is a synchronous reset. clr restarts the line from 0. fast bypasses the divider. tick is combinational from the counter.
// No backpressure. While fast is high the counter is held at 0, so a later return to normal mode gets a full line before its first tick.
module pot_line_timer
  import pokey_pkg::*;
#(
  parameter int LINE_CYCLES = POKEY_LINE_CYCLES
) (
  input  logic o2,
  input  logic rst,
  input  logic clr,
  input  logic fast,
  output logic tick
);

  localparam int TW = $clog2(LINE_CYCLES);
  localparam logic [TW-1:0] LAST = TW'(LINE_CYCLES - 1);

  logic [TW-1:0] line_tmr;

  assign tick = fast | (line_tmr == LAST);

  always_ff @(posedge o2) begin
    if (rst || clr || fast) begin
      line_tmr <= '0;
    end else if (line_tmr == LAST) begin
      line_tmr <= '0;
    end else begin
      line_tmr <= line_tmr + TW'(1);
    end
  end

endmodule

// File: rtl/pot_scan_sequencer.sv
// pot_scan_sequencer: POKEY paddle A/D scan over all 8 pots. POTGO clears the latches and starts the line counter. Each pot latches the counter value when its comparator rises. At MAX_COUNT, pots that never rose are forced to MAX_COUNT.
// Ports: o2 is the clock and rst is a synchronous reset. bus (slave modport) carries potgo_strobe, fast_scan, pot_in and rd_sel in, and rd_data, allpot, dump_en, pot_ctr and scan_busy out.
// Latches are visible one cycle after the comparator edge; rd_data is a combinational mux over them. There is no backpressure, and a POTGO strobe always wins.
module pot_scan_sequencer
  import pokey_pkg::*;
#(
  parameter int LINE_CYCLES = POKEY_LINE_CYCLES,
  parameter int MAX_COUNT   = POT_MAX_COUNT,
  parameter int NUM_POTS    = 8
) (
  input logic                 o2,
  input logic                 rst,
  pot_scan_sequencer_if.slave bus
);

  localparam logic [7:0] MAX_CTR = 8'(MAX_COUNT);

  scan_state_t                 state;
  logic [7:0]                  pot_ctr;
  logic [7:0]                  dump_en_q;
  logic                        scan_busy_q;
  logic                        tick;
  logic [NUM_POTS-1:0][7:0]    pot_q;
  logic [NUM_POTS-1:0]         allpot_q;

  // The strobe overrides latch and terminal handling in the cycle it arrives.
  logic scanning;
  logic latch_en;
  logic term_en;

  assign scanning = (state == SCAN) && !bus.potgo_strobe;
  assign latch_en = scanning && (pot_ctr < MAX_CTR);
  assign term_en  = scanning && (pot_ctr == MAX_CTR);

  // The divider is parked at 0 outside SCAN and on every strobe, so each scan starts at a fresh line boundary.
  pot_line_timer #(
    .LINE_CYCLES(LINE_CYCLES)
  ) u_line_timer (
    .o2   (o2),
    .rst  (rst),
    .clr  (bus.potgo_strobe || (state != SCAN)),
    .fast (bus.fast_scan),
    .tick (tick)
  );

  always_ff @(posedge o2) begin
    if (rst) begin
      state       <= IDLE;
      pot_ctr     <= 8'd0;
      dump_en_q   <= 8'hFF;
      scan_busy_q <= 1'b0;
    end else if (bus.potgo_strobe) begin
      // The same action applies from IDLE (start) and from SCAN (restart).
      state       <= SCAN;
      pot_ctr     <= 8'd0;
      dump_en_q   <= 8'h00;
      scan_busy_q <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          dump_en_q   <= 8'hFF;
          scan_busy_q <= 1'b0;
        end
        SCAN: begin
          if (pot_ctr == MAX_CTR) begin
            // Terminal cycle: the per-pot forcing happens on this same edge.
            state       <= IDLE;
            dump_en_q   <= 8'hFF;
            scan_busy_q <= 1'b0;
          end else if (tick) begin
            pot_ctr <= pot_ctr + 8'd1;
          end
        end
        default: begin
          state       <= IDLE;
          dump_en_q   <= 8'hFF;
          scan_busy_q <= 1'b0;
        end
      endcase
    end
  end

  // Per-pot latch. allpot doubles as the "not yet latched" flag, which makes each latch one-shot until the next POTGO.
  for (genvar i = 0; i < NUM_POTS; i++) begin : g_pot
    logic [7:0] pot_r;
    logic       pend_r;

    always_ff @(posedge o2) begin
      if (rst || bus.potgo_strobe) begin
        pot_r  <= 8'd0;
        pend_r <= 1'b1;
      end else if (pend_r) begin
        if (term_en) begin
          pot_r  <= MAX_CTR;
          pend_r <= 1'b0;
        end else if (latch_en && bus.pot_in[i]) begin
          pot_r  <= pot_ctr;
          pend_r <= 1'b0;
        end
      end
    end

    assign pot_q[i]    = pot_r;
    assign allpot_q[i] = pend_r;
  end

  assign bus.rd_data   = pot_q[bus.rd_sel];
  assign bus.allpot    = allpot_q;
  assign bus.dump_en   = dump_en_q;
  assign bus.pot_ctr   = pot_ctr;
  assign bus.scan_busy = scan_busy_q;

endmodule

// File: tb/tb_pot_scan_sequencer.sv
// tb_pot_scan_sequencer: stimulus and scoreboard for pot_scan_sequencer.
// The expected POT values are queued when the comparator stimulus is driven. They are popped and compared when the scan completes.
// Inputs are driven 1 ns after the rising edge, and outputs are sampled at that same offset.
module tb_pot_scan_sequencer;
  import pokey_pkg::*;

  logic o2;
  logic rst;

  pot_scan_sequencer_if bus ();

  pot_scan_sequencer dut (
    .o2  (o2),
    .rst (rst),
    .bus (bus)
  );

  initial o2 = 1'b0;
  always #10 o2 = ~o2;

  typedef struct {
    int idx;
    int val;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge o2);
      #1;
    end
  endtask

  task automatic push(input int idx, input int val);
    exp_t e;
    e.idx = idx;
    e.val = val;
    sb.push_back(e);
  endtask

  // Expect every pot not in 'skip' to hold val.
  task automatic push_others(input logic [7:0] skip, input int val);
    for (int i = 0; i < 8; i++) begin
      if (!skip[i]) push(i, val);
    end
  endtask

  task automatic drain();
    exp_t e;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      bus.rd_sel = 3'(e.idx);
      #1;
      check($sformatf("pot%0d", e.idx), bus.rd_data, e.val);
    end
  endtask

  // Pulse POTGO for one cycle. On return, the bench sits in SCAN cycle 0.
  task automatic start_scan(input logic fast);
    bus.fast_scan    = fast;
    bus.potgo_strobe = 1'b1;
    step();
    bus.potgo_strobe = 1'b0;
  endtask

  task automatic wait_idle(input int max_cycles);
    int n;
    n = 0;
    while (bus.scan_busy && n < max_cycles) begin
      step();
      n++;
    end
    check("idle_wait", bus.scan_busy, 0);
  endtask

  initial begin
    rst              = 1'b1;
    bus.potgo_strobe = 1'b0;
    bus.fast_scan    = 1'b1;
    bus.pot_in       = 8'h00;
    bus.rd_sel       = 3'd0;
    step(2);
    rst = 1'b0;

    // Reset and idle
    step(10);
    check("rst_allpot", bus.allpot, 8'hFF);
    check("rst_dump", bus.dump_en, 8'hFF);
    check("rst_busy", bus.scan_busy, 0);
    check("rst_ctr", bus.pot_ctr, 0);
    push_others(8'h00, 0);
    drain();

    rst              = 1'b1;
    bus.potgo_strobe = 1'b1;
    step();
    rst              = 1'b0;
    bus.potgo_strobe = 1'b0;
    check("rst_vs_strobe_busy", bus.scan_busy, 0);
    check("rst_vs_strobe_dump", bus.dump_en, 8'hFF);

    // Fast scan: pot 3 latches at 40, the rest time out
    start_scan(1'b1);
    check("fast_c0_ctr", bus.pot_ctr, 0);
    check("fast_c0_dump", bus.dump_en, 8'h00);
    check("fast_c0_busy", bus.scan_busy, 1);
    step(40);
    bus.pot_in = 8'h08;
    push(3, 40);
    step();
    check("fast_allpot_f7", bus.allpot, 8'hF7);
    bus.pot_in = 8'h00;
    step(59);
    bus.pot_in = 8'h08;  // a second rise must be ignored
    step(128);
    check("fast_term_ctr", bus.pot_ctr, POT_MAX_COUNT);
    check("fast_term_busy", bus.scan_busy, 1);
    check("fast_term_dump", bus.dump_en, 8'h00);
    step();
    check("fast_end_busy", bus.scan_busy, 0);
    check("fast_end_dump", bus.dump_en, 8'hFF);
    check("fast_end_allpot", bus.allpot, 8'h00);
    push_others(8'h08, POT_MAX_COUNT);
    drain();
    bus.pot_in = 8'h00;

    // Normal scan: one count per 114-cycle line
    start_scan(1'b0);
    step(113);
    check("norm_c113_ctr", bus.pot_ctr, 0);
    step();
    check("norm_c114_ctr", bus.pot_ctr, 1);
    step(1031);
    check("norm_c1145_ctr", bus.pot_ctr, 10);
    bus.pot_in = 8'h01;
    push(0, 10);
    step();
    check("norm_allpot_fe", bus.allpot, 8'hFE);
    bus.pot_in = 8'h00;
    step(25992 - 1146);
    check("norm_term_ctr", bus.pot_ctr, POT_MAX_COUNT);
    check("norm_term_busy", bus.scan_busy, 1);
    step();
    check("norm_end_busy", bus.scan_busy, 0);
    check("norm_end_dump", bus.dump_en, 8'hFF);
    push_others(8'h01, POT_MAX_COUNT);
    drain();

    // All pots high on the first SCAN cycle
    bus.pot_in = 8'hFF;
    start_scan(1'b1);
    step();
    check("allhi_allpot", bus.allpot, 8'h00);
    check("allhi_busy", bus.scan_busy, 1);
    push_others(8'h00, 0);
    step(227);
    check("allhi_term_busy", bus.scan_busy, 1);
    step();
    check("allhi_end_busy", bus.scan_busy, 0);
    drain();
    bus.pot_in = 8'h00;

    // Restart mid-scan, then a strobe held for several cycles
    start_scan(1'b1);
    step(50);
    bus.pot_in = 8'h04;
    push(2, 50);
    step();
    bus.pot_in = 8'h00;
    check("rs_allpot_fb", bus.allpot, 8'hFB);
    drain();
    step(49);
    check("rs_c100_ctr", bus.pot_ctr, 100);
    bus.potgo_strobe = 1'b1;
    step();
    bus.potgo_strobe = 1'b0;
    check("rs_ctr", bus.pot_ctr, 0);
    check("rs_allpot", bus.allpot, 8'hFF);
    check("rs_busy", bus.scan_busy, 1);
    push(2, 0);
    drain();
    bus.potgo_strobe = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      check($sformatf("hold_strobe_ctr%0d", k), bus.pot_ctr, 0);
    end
    bus.potgo_strobe = 1'b0;
    step(30);
    check("rs2_c30_ctr", bus.pot_ctr, 30);
    bus.pot_in = 8'h04;
    push(2, 30);
    step();
    bus.pot_in = 8'h00;
    push_others(8'h04, POT_MAX_COUNT);
    wait_idle(300);
    drain();

    // Fast to normal switch, then reset mid-scan
    start_scan(1'b1);
    step(20);
    check("sw_c20_ctr", bus.pot_ctr, 20);
    bus.fast_scan = 1'b0;
    step(113);
    check("sw_hold_ctr", bus.pot_ctr, 20);
    step();
    check("sw_tick_ctr", bus.pot_ctr, 21);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("midrst_busy", bus.scan_busy, 0);
    check("midrst_dump", bus.dump_en, 8'hFF);
    check("midrst_allpot", bus.allpot, 8'hFF);
    check("midrst_ctr", bus.pot_ctr, 0);
    push_others(8'h00, 0);
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pot_scan_sequencer.md
Name: pot_scan_sequencer

Overview:
- Sequences the POKEY potentiometer (paddle) A/D scan for all 8 pot inputs.
- On a POTGO write strobe, clears the POT latches and sets ALLPOT to 0xFF. It then releases the dump transistors and runs the line counter (normal mode: one count per scanline; fast mode: one count per o2 cycle).
- Each counter value is latched into a POT register when its comparator input rises. Forces MAX_COUNT on pots that never rise, then re-engages the dump transistors.
- Sits between the POKEY register decode (POTGO/SKCTL/POTn/ALLPOT) and the pot comparator/dump pins.

Parameters:
- LINE_CYCLES, 114, o2 cycles per scanline (normal-mode count tick period).
- MAX_COUNT, 228, terminal count; value forced into unfinished pots.
- NUM_POTS, 8, number of pot channels (fixed at 8 in this revision).

Ports:
- o2  input  1  system clock (phase-2); all state updates on posedge.
- rst  input  1  synchronous, active-high reset.
- potgo_strobe  input  1  one-cycle pulse: CPU wrote POTGO.
- fast_scan  input  1  SKCTL bit 2; 1 = count every o2 cycle.
- pot_in  input  8  comparator outputs; 1 = pot capacitor charged past threshold.
- rd_sel  input  3  POT register select for readback.
- rd_data  output  8  POT[rd_sel], combinational.
- allpot  output  8  bit i = 1 while pot i is still counting.
- dump_en  output  8  per-pot discharge transistor enable (all bits identical).
- pot_ctr  output  8  current line counter value (debug/observability).
- scan_busy  output  1  1 while in SCAN.

Behaviour:
- Reset (rst=1 at posedge) sets:
  - state=IDLE
  - POT[0..7]=0, allpot=0xFF
  - pot_ctr=0, line_tmr=0
  - dump_en=0xFF, scan_busy=0
- Reset has priority over every other input, including potgo_strobe in the same cycle.
- States:
  - IDLE: dump_en=0xFF; POT/allpot hold their values.
  - SCAN: dump_en=0x00, scan_busy=1.
- IDLE -> SCAN on potgo_strobe. The same edge sets POT[*]=0, allpot=0xFF, pot_ctr=0, line_tmr=0.
- SCAN, potgo_strobe=1: restart. Perform the identical clear, stay in SCAN; the strobe overrides any latch or terminal event in that cycle.
- Count tick:
  - fast_scan=1: tick every cycle, and line_tmr is held at 0.
  - fast_scan=0: tick when line_tmr==LINE_CYCLES-1. line_tmr wraps to 0 at that point and otherwise increments.
  - A fast_scan change mid-scan takes effect the next cycle. On a fast->normal change, the first tick comes LINE_CYCLES cycles later.
- On a tick with pot_ctr<MAX_COUNT, pot_ctr increments by 1. pot_ctr never exceeds MAX_COUNT and never wraps.
- Latch rule, every SCAN cycle with pot_ctr<MAX_COUNT: for each i with allpot[i]=1 and pot_in[i]=1, set POT[i]=pot_ctr (pre-increment value) and allpot[i]=0.
- Latching is one-shot per scan: later pot_in toggles are ignored until the next POTGO.
- pot_in already high on the first SCAN cycle gives POT=0.
- Terminal event, first SCAN cycle with pot_ctr==MAX_COUNT:
  - Every i with allpot[i]=1 gets POT[i]=MAX_COUNT and allpot[i]=0, regardless of pot_in.
  - Next state is IDLE, so dump_en=0xFF from the next cycle.
- Multiple pots rising in the same cycle all latch the same value.
- All 8 pots finishing early does not end the scan: SCAN continues to MAX_COUNT. This keeps timing deterministic, matching hardware.
- potgo_strobe held high for multiple cycles restarts every cycle, so pot_ctr stays 0.
- rd_data = POT[rd_sel] combinationally. It reflects a same-cycle latch only after the posedge.
- All counter and latch arithmetic is 8-bit unsigned. line_tmr width is clog2(LINE_CYCLES).

Decomposition:
- Shared package pokey_pkg holds:
  - state enum (IDLE, SCAN)
  - POT_MAX_COUNT=228, POKEY_LINE_CYCLES=114
  - POKEY register offsets POTGO=0xB, SKCTL=0xF, ALLPOT=0x8
- One natural sub-module, pot_line_timer: LINE_CYCLES divider with fast bypass. Interface is o2, rst, clr, fast, producing tick.
- The per-pot latch is a generate loop, not a sub-module.

Test Plan:
- Reset, then idle for 10 cycles -> allpot=0xFF, all POT=0, dump_en=0xFF, scan_busy=0; potgo_strobe with rst both high -> still IDLE.
- Fast mode: strobe, then pot_in[3] rises at SCAN cycle 40 -> POT3=40, allpot=0xF7 on the following cycle. Other pots timeout at cycle 228 -> POT=228, allpot=0x00, dump_en=0xFF next cycle.
- Normal mode: pot_in[0] rises at SCAN cycle 1145 (line 10, offset 5) -> POT0=10. pot_ctr=228 at SCAN cycle 25992; IDLE at cycle 25993.
- pot_in=0xFF on the first SCAN cycle -> all POT=0, allpot=0x00; scan_busy stays 1 until the terminal count.
- Restart: strobe again at fast SCAN cycle 100 after POT2=50 latched -> POT2=0, allpot=0xFF, pot_ctr=0 the next cycle, then a fresh scan.
- Mode switch: fast scan, switch fast_scan to 0 at pot_ctr=20 -> pot_ctr=21 exactly 114 cycles later; rst mid-SCAN -> full reset values on the next cycle.
